sobel_window_gen: RTL and testbench

Raster-scan pixel streamer that builds the 3x3 neighbourhood consumed by the Sobel kernel stage. It accepts one 8-bit pixel per handshake in row-major order and holds the two previous image rows in internal line buffers. For every interior pixel it emits the eight neighbours In0..In7 in kernel order, so the downstream gradient/threshold stage needs no addressing logic. It sits between the image source (memory reader or input FIFO) and the Sobel kernel.

---
 rtl/sobel_window_gen.sv | 168 ++++++++++++++++
 tb/tb_sobel_window_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-scan 3x3 neighbourhood builder for a Sobel kernel.
// Two line buffers hold the previous two rows; a small shift window holds the
// two previous columns. A single output register stage presents the eight
// neighbours of each interior pixel, one cycle after the completing pixel.
module sobel_window_gen #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned XW    = $clog2(IMG_W),
  parameter int unsigned YW    = $clog2(IMG_H)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_sof,
  input  logic [PIX_W-1:0] i_in_pix,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [PIX_W-1:0] o_out_n0,
  output logic [PIX_W-1:0] o_out_n1,
  output logic [PIX_W-1:0] o_out_n2,
  output logic [PIX_W-1:0] o_out_n3,
  output logic [PIX_W-1:0] o_out_n4,
  output logic [PIX_W-1:0] o_out_n5,
  output logic [PIX_W-1:0] o_out_n6,
  output logic [PIX_W-1:0] o_out_n7,
  output logic [XW-1:0]    o_out_x,
  output logic [YW-1:0]    o_out_y,
  output logic             o_out_last
);

  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);
  localparam logic [XW-1:0] XTwo  = XW'(2);
  localparam logic [YW-1:0] YTwo  = YW'(2);

  // Column / row of the next pixel to arrive.
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  // Line buffer A: row y-1. Line buffer B: row y-2. Not reset.
  logic [PIX_W-1:0] r_line_a [IMG_W];
  logic [PIX_W-1:0] r_line_b [IMG_W];

  // Left two columns of the window (index 0 = column x-2, 1 = column x-1).
  // The right column is taken straight from the buffers and the input.
  logic [PIX_W-1:0] r_top [2];
  logic [PIX_W-1:0] r_mid [2];
  logic [PIX_W-1:0] r_bot [2];

  // Output register stage.
  logic             r_out_valid;
  logic             r_out_last;
  logic [PIX_W-1:0] r_nb [8];
  logic [XW-1:0]    r_out_x;
  logic [YW-1:0]    r_out_y;

  logic             w_accept;
  logic             w_emit;
  logic [XW-1:0]    w_x;
  logic [YW-1:0]    w_y;
  logic [XW-1:0]    w_x_next;
  logic [YW-1:0]    w_y_next;
  logic [PIX_W-1:0] w_buf_a;
  logic [PIX_W-1:0] w_buf_b;
  logic             w_last;

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && o_in_ready;

  // Start of frame forces the incoming pixel to (0,0).
  assign w_x = i_in_sof ? '0 : r_x;
  assign w_y = i_in_sof ? '0 : r_y;

  // Pre-write buffer values at the current column.
  assign w_buf_a = r_line_a[w_x];
  assign w_buf_b = r_line_b[w_x];

  assign w_emit = w_accept && (w_x >= XTwo) && (w_y >= YTwo);
  assign w_last = (w_x == XLast) && (w_y == YLast);

  // Next raster position after the accepted pixel, exact wrap at the edges.
  always_comb begin
    w_x_next = w_x + XW'(1);
    w_y_next = w_y;
    if (w_x == XLast) begin
      w_x_next = '0;
      w_y_next = (w_y == YLast) ? '0 : w_y + YW'(1);
    end
  end

  // Raster position counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end
  end

  // Line buffers: the row above moves to the row two above.
  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) begin
      r_line_b[w_x] <= w_buf_a;
      r_line_a[w_x] <= i_in_pix;
    end
  end

  // Shift the window left by one column per accepted pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_top <= '{default: '0};
      r_mid <= '{default: '0};
      r_bot <= '{default: '0};
    end else if (w_accept) begin
      r_top[0] <= r_top[1];
      r_top[1] <= w_buf_b;
      r_mid[0] <= r_mid[1];
      r_mid[1] <= w_buf_a;
      r_bot[0] <= r_bot[1];
      r_bot[1] <= i_in_pix;
    end
  end

  // Output stage: load a completed window, or drain once taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_nb        <= '{default: '0};
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_last;
      r_nb[0]     <= r_top[0];
      r_nb[1]     <= r_top[1];
      r_nb[2]     <= w_buf_b;
      r_nb[3]     <= r_mid[0];
      r_nb[4]     <= w_buf_a;
      r_nb[5]     <= r_bot[0];
      r_nb[6]     <= r_bot[1];
      r_nb[7]     <= i_in_pix;
      r_out_x     <= w_x - XW'(1);
      r_out_y     <= w_y - YW'(1);
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_x     = r_out_x;
  assign o_out_y     = r_out_y;
  assign o_out_n0    = r_nb[0];
  assign o_out_n1    = r_nb[1];
  assign o_out_n2    = r_nb[2];
  assign o_out_n3    = r_nb[3];
  assign o_out_n4    = r_nb[4];
  assign o_out_n5    = r_nb[5];
  assign o_out_n6    = r_nb[6];
  assign o_out_n7    = r_nb[7];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen: a 4x4 instance and a 5x3 instance share the
// same stimulus; an image-array model predicts each window into a queue.
module tb_sobel_window_gen;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_in_valid = 1'b0;
  logic       i_in_sof = 1'b0;
  logic [7:0] i_in_pix = 8'd0;
  logic       i_out_ready = 1'b1;

  logic       a_in_ready, a_out_valid, a_last;
  logic [7:0] a_n0, a_n1, a_n2, a_n3, a_n4, a_n5, a_n6, a_n7;
  logic [1:0] a_x, a_y;
  logic       b_in_ready, b_out_valid, b_last;
  logic [7:0] b_n0, b_n1, b_n2, b_n3, b_n4, b_n5, b_n6, b_n7;
  logic [2:0] b_x;
  logic [1:0] b_y;

  logic [76:0] a_obs, b_obs;
  assign a_obs = {a_n0, a_n1, a_n2, a_n3, a_n4, a_n5, a_n6, a_n7, 6'd0, a_x, 2'd0, a_y, a_last};
  assign b_obs = {b_n0, b_n1, b_n2, b_n3, b_n4, b_n5, b_n6, b_n7, 5'd0, b_x, 2'd0, b_y, b_last};

  int checks = 0;
  int failures = 0;

  // Model state: raster position, current-frame image (stride 8), queue.
  int          m_x, m_y;
  int          m_img [64];
  logic [76:0] q_exp [$];

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(a_in_ready),
    .i_in_sof(i_in_sof), .i_in_pix(i_in_pix), .o_out_valid(a_out_valid),
    .i_out_ready(i_out_ready), .o_out_n0(a_n0), .o_out_n1(a_n1), .o_out_n2(a_n2),
    .o_out_n3(a_n3), .o_out_n4(a_n4), .o_out_n5(a_n5), .o_out_n6(a_n6), .o_out_n7(a_n7),
    .o_out_x(a_x), .o_out_y(a_y), .o_out_last(a_last)
  );

  sobel_window_gen #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) u_dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(b_in_ready),
    .i_in_sof(i_in_sof), .i_in_pix(i_in_pix), .o_out_valid(b_out_valid),
    .i_out_ready(i_out_ready), .o_out_n0(b_n0), .o_out_n1(b_n1), .o_out_n2(b_n2),
    .o_out_n3(b_n3), .o_out_n4(b_n4), .o_out_n5(b_n5), .o_out_n6(b_n6), .o_out_n7(b_n7),
    .o_out_x(b_x), .o_out_y(b_y), .o_out_last(b_last)
  );

  // Record an accepted pixel and push the window it completes, if any.
  task automatic model_accept(input int w, input int h, input int pix, input bit sof,
                              output bit emit);
    int x, y;
    x = sof ? 0 : m_x;
    y = sof ? 0 : m_y;
    m_img[y*8+x] = pix;
    emit = 1'b0;
    if (x >= 2 && y >= 2) begin
      q_exp.push_back({8'(m_img[(y-2)*8+x-2]), 8'(m_img[(y-2)*8+x-1]), 8'(m_img[(y-2)*8+x]),
                       8'(m_img[(y-1)*8+x-2]), 8'(m_img[(y-1)*8+x]),
                       8'(m_img[y*8+x-2]), 8'(m_img[y*8+x-1]), 8'(pix),
                       8'(x-1), 4'(y-1), (x == w-1) && (y == h-1)});
      emit = 1'b1;
    end
    if (x == w-1) begin
      m_x = 0;
      m_y = (y == h-1) ? 0 : y + 1;
    end else begin
      m_x = x + 1;
      m_y = y;
    end
  endtask

  // Drive one cycle; report handshakes and the selected DUT's outputs.
  task automatic step(input bit v, input bit s, input int pix, input bit rdy, input bit use_b,
                      output bit acc, output bit fire, output bit ov, output bit ir,
                      output bit emit, output logic [76:0] obs);
    i_in_valid  = v;
    i_in_sof    = s;
    i_in_pix    = 8'(pix);
    i_out_ready = rdy;
    @(negedge clk);
    ir   = use_b ? b_in_ready : a_in_ready;
    ov   = use_b ? b_out_valid : a_out_valid;
    obs  = use_b ? b_obs : a_obs;
    acc  = v && ir;
    fire = ov && rdy;
    emit = 1'b0;
    if (acc) model_accept(use_b ? 5 : 4, use_b ? 3 : 4, pix, s, emit);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst       = 1'b1;
    i_in_valid  = 1'b0;
    i_in_sof    = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    m_x = 0;
    m_y = 0;
    q_exp.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if (a_obs !== 77'd0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", a_obs);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_obs} !== {1'b0, 1'b1, 77'd0}) begin
      failures++; $display("FAIL reset_b: got %b %b %h want 0 1 0", b_out_valid, b_in_ready, b_obs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    bit acc, fire, ov, ir, emit, prev_emit;
    logic [76:0] obs, exp_w, first_w, last_w;
    int p, nwin;
    first_w = {8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10, 8'd1, 4'd1, 1'b0};
    last_w  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd11, 8'd13, 8'd14, 8'd15, 8'd2, 4'd2, 1'b1};
    apply_reset();
    p = 0; nwin = 0; prev_emit = 1'b0;
    for (int c = 0; c < 24; c++) begin
      step(p < 16, p == 0, p, 1'b1, 1'b0, acc, fire, ov, ir, emit, obs);
      checks++;
      if (fire !== prev_emit) begin
        failures++; $display("FAIL stream_latency: cycle %0d out_valid=%b want %b", c, fire, prev_emit);
      end
      prev_emit = emit;
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL stream_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL stream_window: got %h want %h", obs, exp_w);
          end
        end
        if (nwin == 1) begin
          checks++;
          if (obs !== first_w) begin
            failures++; $display("FAIL stream_first: got %h want %h", obs, first_w);
          end
        end
        if (nwin == 4) begin
          checks++;
          if (obs !== last_w) begin
            failures++; $display("FAIL stream_last: got %h want %h", obs, last_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 4 || q_exp.size() != 0) begin
      failures++; $display("FAIL stream_count: got %0d windows want 4", nwin);
    end
  endtask

  task automatic test_stall();
    bit acc, fire, ov, ir, emit;
    logic [76:0] obs, exp_w, held;
    int p, nwin;
    apply_reset();
    p = 0; nwin = 0; held = '0;
    for (int c = 0; c < 32; c++) begin
      step(p < 16, p == 0, p, !(c >= 11 && c < 16), 1'b0, acc, fire, ov, ir, emit, obs);
      if (c == 11) held = obs;
      if (c >= 11 && c < 16) begin
        checks++;
        if (ov !== 1'b1 || ir !== 1'b0 || obs !== held) begin
          failures++;
          $display("FAIL stall_hold: cycle %0d valid=%b ready=%b out=%h want 1 0 %h",
                   c, ov, ir, obs, held);
        end
      end
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL stall_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL stall_window: got %h want %h", obs, exp_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 4 || q_exp.size() != 0 || p != 16) begin
      failures++; $display("FAIL stall_count: got %0d windows %0d pixels want 4 16", nwin, p);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, fire, ov, ir, emit;
    logic [76:0] obs, exp_w;
    int p, nwin;
    apply_reset();
    p = 0; nwin = 0;
    for (int c = 0; c < 40; c++) begin
      // Second frame pixels are offset so any leakage from frame 1 shows up.
      step(p < 32, p == 0 || p == 16, (p < 16) ? p : p + 84, 1'b1, 1'b0,
           acc, fire, ov, ir, emit, obs);
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL b2b_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL b2b_window: got %h want %h", obs, exp_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 8 || q_exp.size() != 0) begin
      failures++; $display("FAIL b2b_count: got %0d windows want 8", nwin);
    end
  endtask

  task automatic test_mid_sof();
    bit acc, fire, ov, ir, emit;
    logic [76:0] obs, exp_w;
    int p, nwin;
    apply_reset();
    p = 0; nwin = 0;
    for (int c = 0; c < 32; c++) begin
      // 7 pixels of an aborted frame, then a full frame restarted by sof.
      step(p < 23, p == 0 || p == 7, (p < 7) ? 200 + p : 30 + p, 1'b1, 1'b0,
           acc, fire, ov, ir, emit, obs);
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL midsof_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL midsof_window: got %h want %h", obs, exp_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 4 || q_exp.size() != 0) begin
      failures++; $display("FAIL midsof_count: got %0d windows want 4", nwin);
    end
  endtask

  task automatic test_reset_mid();
    bit acc, fire, ov, ir, emit;
    logic [76:0] obs, exp_w;
    int p, nwin;
    apply_reset();
    p = 0;
    // Pixels 0..10; pixel 10 at (2,2) leaves a window in flight.
    for (int c = 0; c < 11; c++) begin
      step(1'b1, 1'b0, p, 1'b1, 1'b0, acc, fire, ov, ir, emit, obs);
      if (acc) p++;
    end
    i_rst      = 1'b1;
    i_in_valid = 1'b1;
    i_in_pix   = 8'd11;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    m_x = 0;
    m_y = 0;
    q_exp.delete();
    i_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_valid: got %b want 0", a_out_valid);
    end
    @(posedge clk);
    #1;
    p = 0; nwin = 0;
    for (int c = 0; c < 24; c++) begin
      step(p < 16, 1'b0, 50 + p, 1'b1, 1'b0, acc, fire, ov, ir, emit, obs);
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL rstmid_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL rstmid_window: got %h want %h", obs, exp_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 4 || q_exp.size() != 0) begin
      failures++; $display("FAIL rstmid_count: got %0d windows want 4", nwin);
    end
  endtask

  task automatic test_non_pow2();
    bit acc, fire, ov, ir, emit;
    logic [76:0] obs, exp_w, last_w;
    int p, nwin;
    last_w = {8'd2, 8'd3, 8'd4, 8'd7, 8'd9, 8'd12, 8'd13, 8'd14, 8'd3, 4'd1, 1'b1};
    apply_reset();
    p = 0; nwin = 0;
    for (int c = 0; c < 22; c++) begin
      step(p < 15, p == 0, p, 1'b1, 1'b1, acc, fire, ov, ir, emit, obs);
      if (fire) begin
        nwin++;
        checks++;
        if (q_exp.size() == 0) begin
          failures++; $display("FAIL np2_window: unexpected %h want none", obs);
        end else begin
          exp_w = q_exp.pop_front();
          if (obs !== exp_w) begin
            failures++; $display("FAIL np2_window: got %h want %h", obs, exp_w);
          end
        end
        if (nwin == 3) begin
          checks++;
          if (obs !== last_w) begin
            failures++; $display("FAIL np2_last: got %h want %h", obs, last_w);
          end
        end
      end
      if (acc) p++;
    end
    checks++;
    if (nwin != 3 || q_exp.size() != 0) begin
      failures++; $display("FAIL np2_count: got %0d windows want 3", nwin);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    test_non_pow2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
